// File: rtl/capture_pkg.sv
// Shared types for the capture controller: FSM states and trigger edge encoding.
package capture_pkg;
  typedef enum logic [2:0] {IDLE, PRE_FILL, ARMED, POST, DONE} state_e;
  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;
endpackage

// File: rtl/capture_trig_detect.sv
// Level-crossing trigger: remembers the previous accepted sample and flags a
// single-cycle hit when the current sample crosses the threshold (or is forced).
module trig_detect
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  smp_vld_i,
  input  logic [DATA_WIDTH-1:0] smp_i,
  input  logic [DATA_WIDTH-1:0] level_i,
  input  logic                  edge_sel_i,
  input  logic                  force_i,
  output logic                  hit_o
);
  logic [DATA_WIDTH-1:0] prev_q;
  logic                  pv_q;
  logic                  rise, fall, crossed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      pv_q   <= 1'b0;
    end else if (clr_i) begin
      pv_q   <= 1'b0;
    end else if (smp_vld_i) begin
      prev_q <= smp_i;
      pv_q   <= 1'b1;
    end
  end

  assign rise    = (prev_q < level_i) && (smp_i >= level_i);
  assign fall    = (prev_q > level_i) && (smp_i <= level_i);
  assign crossed = pv_q && ((edge_sel_i == EDGE_FALL) ? fall : rise);
  assign hit_o   = en_i && smp_vld_i && (force_i || crossed);
endmodule

// File: rtl/capture_ctrl.sv
// Circular-buffer acquisition controller: pre-fill, trigger, post-fill, then
// maps linear readout indices (0 = oldest pre-trigger sample) to RAM addresses.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  force_trig,
  input  logic                  edge_sel,
  input  logic [DATA_WIDTH-1:0] level,
  input  logic [ADDR_WIDTH-1:0] pre_len,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [ADDR_WIDTH-1:0] rd_index,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr_in,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic                  busy,
  output logic                  armed,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wp_q, pre_q, trig_q, wa_q;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_nxt, post_tgt;
  logic [DATA_WIDTH-1:0] lvl_q, wd_q;
  logic                  edge_q, we_q, cs_q;
  logic                  acc, hit, in_run;

  // pre_len is ADDR_WIDTH wide, so it can never exceed DEPTH-1: the clamp is inherent.
  assign in_run   = (state_q == PRE_FILL) || (state_q == ARMED) || (state_q == POST);
  assign acc      = s_valid && in_run && !arm && !abort;
  assign cnt_nxt  = cnt_q + ONE_C;
  assign post_tgt = DEPTH_C - {1'b0, pre_q};

  trig_detect #(.DATA_WIDTH(DATA_WIDTH)) u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (arm),
    .en_i       (state_q == ARMED),
    .smp_vld_i  (acc),
    .smp_i      (s_data),
    .level_i    (lvl_q),
    .edge_sel_i (edge_q),
    .force_i    (force_trig),
    .hit_o      (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wp_q    <= '0;
      pre_q   <= '0;
      trig_q  <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      lvl_q   <= '0;
      edge_q  <= EDGE_RISE;
      we_q    <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      cs_q <= 1'b1;
      we_q <= acc;
      if (acc) begin
        wa_q <= wp_q;
        wd_q <= s_data;
        wp_q <= wp_q + 1'b1;
      end
      if (abort) begin
        state_q <= IDLE;
      end else if (arm) begin
        pre_q   <= pre_len;
        lvl_q   <= level;
        edge_q  <= edge_sel;
        cnt_q   <= '0;
        state_q <= (pre_len == '0) ? ARMED : PRE_FILL;
      end else if (acc) begin
        case (state_q)
          PRE_FILL: begin
            cnt_q <= cnt_nxt;
            if (cnt_nxt == {1'b0, pre_q}) state_q <= ARMED;
          end
          ARMED: if (hit) begin
            trig_q  <= wp_q;
            cnt_q   <= ONE_C;
            state_q <= (post_tgt == ONE_C) ? DONE : POST;
          end
          POST: begin
            cnt_q <= cnt_nxt;
            if (cnt_nxt == post_tgt) state_q <= DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign ram_cs       = cs_q;
  assign ram_we       = we_q;
  assign ram_addr_in  = wa_q;
  assign ram_data_in  = wd_q;
  assign busy         = in_run;
  assign armed        = (state_q == ARMED);
  assign done         = (state_q == DONE);
  assign ram_oe       = done;
  assign trig_addr    = trig_q;
  assign ram_addr_out = done ? (trig_q - pre_q + rd_index) : '0;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl at DEPTH=16 with a behavioural sample RAM.
module tb_capture_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 0, abort = 0, force_trig = 0, edge_sel = 0, s_valid = 0;
  logic [7:0] level = 0, s_data = 0;
  logic [3:0] pre_len = 0, rd_index = 0;
  logic       ram_cs, ram_we, ram_oe, busy, armed, done;
  logic [3:0] ram_addr_in, ram_addr_out, trig_addr;
  logic [7:0] ram_data_in;
  logic [7:0] mem [16];
  logic [3:0] exp_wp;
  int         pass = 0, tot = 0;

  capture_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .force_trig(force_trig),
    .edge_sel(edge_sel), .level(level), .pre_len(pre_len), .s_valid(s_valid),
    .s_data(s_data), .rd_index(rd_index), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_oe(ram_oe), .ram_addr_in(ram_addr_in), .ram_data_in(ram_data_in),
    .ram_addr_out(ram_addr_out), .busy(busy), .armed(armed), .done(done),
    .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_we) mem[ram_addr_in] <= ram_data_in;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic f);
    s_valid = 1; s_data = d; force_trig = f;
    step();
    s_valid = 0; force_trig = 0;
    exp_wp = exp_wp + 4'd1;
  endtask

  task automatic do_arm(input logic e, input logic [7:0] l, input logic [3:0] p);
    edge_sel = e; level = l; pre_len = p; arm = 1;
    step();
    arm = 0;
  endtask

  task automatic test_reset();
    #3;
    tot++; if ({ram_cs, ram_we, ram_oe, busy, armed, done} !== 6'b0) $display("FAIL rst_flags got %b exp 000000", {ram_cs, ram_we, ram_oe, busy, armed, done}); else pass++;
    tot++; if ({ram_addr_in, ram_data_in, ram_addr_out, trig_addr} !== 20'h0) $display("FAIL rst_buses got %h exp 0", {ram_addr_in, ram_data_in, ram_addr_out, trig_addr}); else pass++;
    rst_n = 1; exp_wp = 0;
    step();
    tot++; if (ram_cs !== 1'b1) $display("FAIL cs_after_rst got %b exp 1", ram_cs); else pass++;
    do_arm(0, 8'h80, 4'd0);
    send(8'h11, 1); send(8'h22, 0);
    tot++; if ({busy, armed, done} !== 3'b100) $display("FAIL in_post got %b exp 100", {busy, armed, done}); else pass++;
    #2 rst_n = 0;
    #1;
    tot++; if ({ram_cs, ram_we, busy, armed, done} !== 5'b0) $display("FAIL rst_async_flags got %b exp 00000", {ram_cs, ram_we, busy, armed, done}); else pass++;
    tot++; if ({ram_addr_in, ram_data_in, trig_addr} !== 16'h0) $display("FAIL rst_async_buses got %h exp 0", {ram_addr_in, ram_data_in, trig_addr}); else pass++;
    rst_n = 1; exp_wp = 0;
    step();
  endtask

  task automatic test_rising();
    do_arm(0, 8'h80, 4'd4);
    tot++; if ({busy, armed} !== 2'b10) $display("FAIL rise_prefill got %b exp 10", {busy, armed}); else pass++;
    for (int k = 0; k < 20; k++) begin
      send(8'(k * 16), 0);
      tot++; if (ram_we !== 1'b1 || ram_addr_in !== 4'(k) || ram_data_in !== 8'(k * 16)) $display("FAIL rise_wr%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", k, ram_we, ram_addr_in, ram_data_in, 4'(k), 8'(k * 16)); else pass++;
      if (k == 3) begin tot++; if (armed !== 1'b1) $display("FAIL rise_armed got %b exp 1", armed); else pass++; end
      if (k == 7) begin tot++; if (armed !== 1'b1) $display("FAIL rise_no_early got %b exp 1", armed); else pass++; end
      if (k == 8) begin tot++; if (trig_addr !== 4'd8 || armed !== 1'b0) $display("FAIL rise_trig got %h/%b exp 8/0", trig_addr, armed); else pass++; end
      if (k == 18) begin tot++; if (done !== 1'b0) $display("FAIL rise_early_done got %b exp 0", done); else pass++; end
    end
    tot++; if ({done, ram_oe, busy} !== 3'b110) $display("FAIL rise_done got %b exp 110", {done, ram_oe, busy}); else pass++;
    s_valid = 1; s_data = 8'hAA;
    step();
    s_valid = 0;
    tot++; if (ram_we !== 1'b0) $display("FAIL rise_done_nowr got %b exp 0", ram_we); else pass++;
    for (int i = 0; i < 16; i++) begin
      rd_index = 4'(i); #1;
      tot++; if (ram_addr_out !== 4'(4 + i) || mem[ram_addr_out] !== 8'(((4 + i) % 16) * 16)) $display("FAIL rise_rd%0d got a=%h d=%h exp a=%h d=%h", i, ram_addr_out, mem[ram_addr_out], 4'(4 + i), 8'(((4 + i) % 16) * 16)); else pass++;
    end
    rd_index = 0;
  endtask

  task automatic test_falling();
    logic [3:0] t;
    do_arm(1, 8'h50, 4'd0);
    send(8'h60, 0); send(8'h60, 0);
    tot++; if (armed !== 1'b1) $display("FAIL fall_wait got %b exp 1", armed); else pass++;
    t = exp_wp;
    send(8'h50, 0);
    tot++; if (armed !== 1'b0 || busy !== 1'b1 || trig_addr !== t) $display("FAIL fall_trig got a=%b t=%h exp a=0 t=%h", armed, trig_addr, t); else pass++;
    do_arm(1, 8'h50, 4'd0);
    send(8'h50, 0); send(8'h50, 0); send(8'h50, 0);
    tot++; if (armed !== 1'b1) $display("FAIL fall_flat got %b exp 1", armed); else pass++;
  endtask

  task automatic test_force();
    logic [3:0] t;
    do_arm(0, 8'h80, 4'd0);
    t = exp_wp;
    send(8'h01, 1);
    tot++; if (trig_addr !== t || busy !== 1'b1) $display("FAIL force_trig got %h exp %h", trig_addr, t); else pass++;
    for (int k = 0; k < 15; k++) begin
      send(8'(k), 0);
      if (k == 13) begin tot++; if (done !== 1'b0) $display("FAIL force_early got %b exp 0", done); else pass++; end
    end
    tot++; if (done !== 1'b1 || exp_wp !== t) $display("FAIL force_done got %b exp 1", done); else pass++;
    rd_index = 0; #1;
    tot++; if (ram_addr_out !== t) $display("FAIL force_rd0 got %h exp %h", ram_addr_out, t); else pass++;
    rd_index = 15; #1;
    tot++; if (ram_addr_out !== t - 4'd1) $display("FAIL force_rd15 got %h exp %h", ram_addr_out, t - 4'd1); else pass++;
    rd_index = 0;
  endtask

  task automatic test_gaps();
    logic [3:0] t0;
    do_arm(0, 8'h80, 4'd4);
    t0 = exp_wp;
    for (int k = 0; k < 20; k++) begin
      send(8'(k * 16), 0);
      tot++; if (ram_we !== 1'b1 || ram_addr_in !== t0 + 4'(k)) $display("FAIL gap_wr%0d got we=%b a=%h exp we=1 a=%h", k, ram_we, ram_addr_in, t0 + 4'(k)); else pass++;
      if (k < 19) for (int g = 0; g < 3; g++) begin
        step();
        tot++; if (ram_we !== 1'b0) $display("FAIL gap_idle%0d got %b exp 0", k, ram_we); else pass++;
      end
      if (k == 18) begin tot++; if (done !== 1'b0) $display("FAIL gap_early got %b exp 0", done); else pass++; end
    end
    tot++; if (done !== 1'b1 || trig_addr !== t0 + 4'd8) $display("FAIL gap_done got d=%b t=%h exp d=1 t=%h", done, trig_addr, t0 + 4'd8); else pass++;
  endtask

  task automatic test_rearm();
    logic [3:0] t;
    do_arm(0, 8'h80, 4'd2);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 1); send(8'h00, 0);
    tot++; if ({busy, armed, done} !== 3'b100) $display("FAIL rearm_post got %b exp 100", {busy, armed, done}); else pass++;
    do_arm(0, 8'h80, 4'd3);
    tot++; if ({busy, armed} !== 2'b10) $display("FAIL rearm_prefill got %b exp 10", {busy, armed}); else pass++;
    t = exp_wp + 4'd3;
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    tot++; if (armed !== 1'b1) $display("FAIL rearm_armed got %b exp 1", armed); else pass++;
    send(8'h00, 1);
    tot++; if (trig_addr !== t) $display("FAIL rearm_trig got %h exp %h", trig_addr, t); else pass++;
    do_arm(0, 8'h80, 4'd0);
    abort = 1; arm = 1; step(); abort = 0; arm = 0;
    tot++; if ({busy, armed, done} !== 3'b000) $display("FAIL abort_wins got %b exp 000", {busy, armed, done}); else pass++;
    do_arm(0, 8'h80, 4'd0);
    abort = 1; step(); abort = 0;
    tot++; if ({busy, armed, done} !== 3'b000) $display("FAIL abort_idle got %b exp 000", {busy, armed, done}); else pass++;
    s_valid = 1; s_data = 8'h90; force_trig = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      tot++; if (ram_we !== 1'b0 || trig_addr !== t) $display("FAIL abort_nowr%0d got we=%b t=%h exp we=0 t=%h", k, ram_we, trig_addr, t); else pass++;
    end
    s_valid = 0; force_trig = 0;
    do_arm(0, 8'h80, 4'd15);
    t = exp_wp;
    for (int k = 0; k < 15; k++) send(8'h00, 0);
    tot++; if (armed !== 1'b1) $display("FAIL pre15_armed got %b exp 1", armed); else pass++;
    send(8'h00, 1);
    tot++; if (done !== 1'b1 || trig_addr !== t + 4'd15) $display("FAIL pre15_done got d=%b t=%h exp d=1 t=%h", done, trig_addr, t + 4'd15); else pass++;
    rd_index = 0; #1;
    tot++; if (ram_addr_out !== t) $display("FAIL pre15_rd0 got %h exp %h", ram_addr_out, t); else pass++;
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_force();
    test_gaps();
    test_rearm();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
